// File: rtl/rx_bit_decoder_usb_if.sv
// ----------------------------------------------------------------------------
// rx_bit_decoder_usb_if
// Purpose : groups the USB receive front-end pins and decoded outputs.
// Signals : d_plus, d_minus      raw asynchronous USB line inputs
//           d_edge               1-cycle pulse on any synchronized D+ transition
//           eop                  level, high while the receiver is in EOP
//           shift_enable         1-cycle pulse per decoded, non-stuffed bit
//           byte_recieved        1-cycle pulse, rx_packet_data holds a full byte
//           rx_packet_data[7:0]  assembled byte, first received bit in bit 0
//           stuff_err            bit-stuff violation pulse (RX_STUFF_ERR_EN only)
// Modports: master = decoder side, slave = line driver / consumer side.
// Config  : RX_STUFF_ERR_EN adds stuff_err.
// ----------------------------------------------------------------------------
interface rx_bit_decoder_usb_if;
    logic       d_plus;
    logic       d_minus;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_recieved;
    logic [7:0] rx_packet_data;
`ifdef RX_STUFF_ERR_EN
    logic       stuff_err;

    modport master (
        input  d_plus, d_minus,
        output d_edge, eop, shift_enable, byte_recieved, rx_packet_data, stuff_err
    );
    modport slave (
        output d_plus, d_minus,
        input  d_edge, eop, shift_enable, byte_recieved, rx_packet_data, stuff_err
    );
`else
    modport master (
        input  d_plus, d_minus,
        output d_edge, eop, shift_enable, byte_recieved, rx_packet_data
    );
    modport slave (
        output d_plus, d_minus,
        input  d_edge, eop, shift_enable, byte_recieved, rx_packet_data
    );
`endif
endinterface

// File: rtl/rx_bit_decoder_usb.sv
// ----------------------------------------------------------------------------
// rx_bit_decoder_usb
// Purpose : USB receive front end. Synchronizes D+/D-, recovers bit timing,
//           NRZI-decodes, strips stuffed bits, assembles LSB-first bytes and
//           flags EOP for rx_rcu_usb.
// Ports   : clk  system clock
//           rst  synchronous active-high reset
//           bus  rx_bit_decoder_usb_if.master (line inputs, decoded outputs)
// Params  : CLKS_PER_BIT  clk cycles per USB bit time (even, >= 4)
// Config  : RX_STUFF_ERR_EN  enables stuff_err and the error/EOP-wait state.
// ----------------------------------------------------------------------------
module rx_bit_decoder_usb #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_bit_decoder_usb_if.master bus
);
    localparam int unsigned TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MID  = TIMER_W'(CLKS_PER_BIT / 2);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] ONES_STUFF = 3'd6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_EOP    = 2'd2;
`ifdef RX_STUFF_ERR_EN
    localparam logic [1:0] ST_ERR    = 2'd3;
`endif

    logic               s1_dp_q, s1_dp_d, s2_dp_q, s2_dp_d;
    logic               s1_dm_q, s1_dm_d, s2_dm_q, s2_dm_d;
    logic               d_edge_q, d_edge_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         state_q, state_d;
    logic               prev_bit_q, prev_bit_d;
    logic [2:0]         ones_q, ones_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         data_q, data_d;
    logic               shift_q, shift_d;
    logic               byte_q, byte_d;
    logic               eop_q, eop_d;
`ifdef RX_STUFF_ERR_EN
    logic               stuff_err_q, stuff_err_d;
`endif

    logic strobe;
    logic se0;
    logic line_j;
    logic nrzi_bit;

    // State and datapath registers; sync chain and prev_bit reset to the J line state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_dp_q     <= 1'b1;
            s2_dp_q     <= 1'b1;
            s1_dm_q     <= 1'b0;
            s2_dm_q     <= 1'b0;
            d_edge_q    <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
            prev_bit_q  <= 1'b1;
            ones_q      <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            shift_q     <= 1'b0;
            byte_q      <= 1'b0;
            eop_q       <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            stuff_err_q <= 1'b0;
`endif
        end else begin
            s1_dp_q     <= s1_dp_d;
            s2_dp_q     <= s2_dp_d;
            s1_dm_q     <= s1_dm_d;
            s2_dm_q     <= s2_dm_d;
            d_edge_q    <= d_edge_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
            prev_bit_q  <= prev_bit_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            eop_q       <= eop_d;
`ifdef RX_STUFF_ERR_EN
            stuff_err_q <= stuff_err_d;
`endif
        end
    end

    // Synchronizer, bit timing, NRZI decode, destuffing and packet FSM.
    always_comb begin
        s1_dp_d    = bus.d_plus;
        s2_dp_d    = s1_dp_q;
        s1_dm_d    = bus.d_minus;
        s2_dm_d    = s1_dm_q;
        // Registering s1^s2 yields exactly s2^s3 of a three-flop D+ chain.
        d_edge_d   = s1_dp_q ^ s2_dp_q;
        timer_d    = timer_q;
        state_d    = state_q;
        prev_bit_d = prev_bit_q;
        ones_d     = ones_q;
        bitcnt_d   = bitcnt_q;
        data_d     = data_q;
        shift_d    = 1'b0;
        // Byte completes one cycle after the shift that wrapped bitcnt to 0.
        byte_d     = shift_q && (bitcnt_q == 3'd0);
        eop_d      = eop_q;
`ifdef RX_STUFF_ERR_EN
        stuff_err_d = 1'b0;
`endif

        se0      = !s2_dp_q && !s2_dm_q;
        line_j   = s2_dp_q && !s2_dm_q;
        nrzi_bit = (s2_dp_q == prev_bit_q);

        // Every edge resyncs the timer so the strobe lands mid-bit.
        if (state_q == ST_IDLE || d_edge_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        strobe = (state_q != ST_IDLE) && (timer_q == TIMER_MID) && !d_edge_q;

        if (strobe && !se0) begin
            prev_bit_d = s2_dp_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (d_edge_q) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (strobe) begin
                    if (se0) begin
                        eop_d   = 1'b1;
                        state_d = ST_EOP;
                    end else if (ones_q == ONES_STUFF) begin
                        // Stuffed position: bit is dropped, only the run counter clears.
                        ones_d = '0;
`ifdef RX_STUFF_ERR_EN
                        if (nrzi_bit) begin
                            stuff_err_d = 1'b1;
                            state_d     = ST_ERR;
                        end
`endif
                    end else begin
                        shift_d  = 1'b1;
                        data_d   = {nrzi_bit, data_q[7:1]};
                        ones_d   = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            ST_EOP: begin
                // A K strobe here is left for rx_rcu_usb to treat as an error.
                if (strobe && line_j) begin
                    state_d    = ST_IDLE;
                    eop_d      = 1'b0;
                    bitcnt_d   = '0;
                    ones_d     = '0;
                    prev_bit_d = 1'b1;
                end
            end
`ifdef RX_STUFF_ERR_EN
            ST_ERR: begin
                // Wait out the corrupt packet until a real SE0 arrives.
                if (strobe && se0) begin
                    eop_d   = 1'b1;
                    state_d = ST_EOP;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.d_edge         = d_edge_q;
    assign bus.eop            = eop_q;
    assign bus.shift_enable   = shift_q;
    assign bus.byte_recieved  = byte_q;
    assign bus.rx_packet_data = data_q;
`ifdef RX_STUFF_ERR_EN
    assign bus.stuff_err      = stuff_err_q;
`endif

endmodule
